// File: rtl/fdn_out_fifo.sv
// Output stage for the FDN MAC core: narrows Re/Im, buffers in a FWFT FIFO, drives an AXI-Stream-style master.
// Define FDN_OUT_SAT_EN to saturate on narrowing (and drive sat_pulse); otherwise components wrap.
module fdn_out_fifo #(
    parameter int unsigned W_IN  = 32,
    parameter int unsigned W_OUT = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld_in,
    input  logic                   last_in,
    input  logic [W_IN-1:0]        re_in,
    input  logic [W_IN-1:0]        im_in,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [2*W_OUT-1:0]     m_tdata,
    output logic                   m_tlast,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   sat_pulse
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned MW = 2 * W_OUT + 1;

    logic [W_OUT-1:0] w_re_n;
    logic [W_OUT-1:0] w_im_n;
    logic             w_clip;

`ifdef FDN_OUT_SAT_EN
    // Returns {clipped, value}; in range when all bits above the output sign bit match it.
    function automatic logic [W_OUT:0] narrow(input logic [W_IN-1:0] x);
        logic [W_IN-W_OUT:0] hi;
        hi = x[W_IN-1:W_OUT-1];
        if ((&hi) || !(|hi))
            narrow = {1'b0, x[W_OUT-1:0]};
        else if (x[W_IN-1])
            narrow = {1'b1, 1'b1, {(W_OUT-1){1'b0}}};
        else
            narrow = {1'b1, 1'b0, {(W_OUT-1){1'b1}}};
    endfunction

    logic [W_OUT:0] w_re_q;
    logic [W_OUT:0] w_im_q;

    assign w_re_q = narrow(re_in);
    assign w_im_q = narrow(im_in);
    assign w_re_n = w_re_q[W_OUT-1:0];
    assign w_im_n = w_im_q[W_OUT-1:0];
    assign w_clip = w_re_q[W_OUT] | w_im_q[W_OUT];
`else
    logic w_unused_hi;

    assign w_re_n      = re_in[W_OUT-1:0];
    assign w_im_n      = im_in[W_OUT-1:0];
    assign w_clip      = 1'b0;
    assign w_unused_hi = ^{re_in, im_in};
`endif

    logic             r_s1_vld;
    logic             r_s1_last;
    logic [W_OUT-1:0] r_s1_re;
    logic [W_OUT-1:0] r_s1_im;
    logic             r_sat;

    // Stage 1: unconditional capture; the core cannot be stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_re   <= '0;
            r_s1_im   <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_s1_vld  <= vld_in;
            r_s1_last <= last_in;
            r_s1_re   <= w_re_n;
            r_s1_im   <= w_im_n;
            r_sat     <= vld_in & w_clip;
        end
    end

    logic [MW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [MW-1:0] w_rd_word;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_count != '0) & m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr   = r_s1_vld & (~w_full | w_pop);
    assign w_drop = r_s1_vld & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop)
                r_count <= r_count - CW'(1);
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    // Storage array carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {r_s1_last, r_s1_im, r_s1_re};
    end

    assign w_rd_word = r_mem[r_rd_ptr];
    assign m_tvalid  = (r_count != '0);
    assign m_tdata   = w_rd_word[2*W_OUT-1:0];
    assign m_tlast   = w_rd_word[2*W_OUT];
    assign level     = r_count;
    assign ovf       = r_ovf;
    assign sat_pulse = r_sat;

endmodule
